// File: rtl/reg_split.sv
// Word-stream to pair splitter: alternate input words land in out1 then out2,
// and the pair is held until the consumer acks it.
module reg_split #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    input  logic             ack,
    output logic             rdy,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             valid,
    output logic             ovr,
    output logic [3:0]       pair_cnt
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HALF  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;
    logic             ovr_q, ovr_d;
    logic [3:0]       pair_cnt_q, pair_cnt_d;

    // A held pair can be replaced in the same cycle it is acked.
    assign rdy = (state_q != FULL) || ack;

    always_comb begin
        state_d    = state_q;
        out1_d     = out1_q;
        out2_d     = out2_q;
        pair_cnt_d = pair_cnt_q;
        ovr_d      = ovr_q | (en & ~rdy);
        case (state_q)
            EMPTY: begin
                if (en) begin
                    out1_d  = in;
                    state_d = HALF;
                end
            end
            HALF: begin
                if (en) begin
                    out2_d  = in;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (ack) begin
                    pair_cnt_d = pair_cnt_q + 4'd1;
                    if (en) begin
                        out1_d  = in;
                        state_d = HALF;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            out1_q     <= '0;
            out2_q     <= '0;
            ovr_q      <= 1'b0;
            pair_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            out1_q     <= out1_d;
            out2_q     <= out2_d;
            ovr_q      <= ovr_d;
            pair_cnt_q <= pair_cnt_d;
        end
    end

    assign out1     = out1_q;
    assign out2     = out2_q;
    assign valid    = (state_q == FULL);
    assign ovr      = ovr_q;
    assign pair_cnt = pair_cnt_q;

endmodule

// File: tb/tb_reg_split.sv
// Randomized and directed bench for reg_split against a queue-based pairing model.
module tb_reg_split;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] in;
    logic       ack;
    logic       rdy;
    logic [7:0] out1;
    logic [7:0] out2;
    logic       valid;
    logic       ovr;
    logic [3:0] pair_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: words accepted but not yet consumed, plus visible outputs.
    logic [7:0] pend[$];
    logic [7:0] m_out1, m_out2;
    logic       m_ovr;
    int         m_cnt;

    reg_split #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in       (in),
        .ack      (ack),
        .rdy      (rdy),
        .out1     (out1),
        .out2     (out2),
        .valid    (valid),
        .ovr      (ovr),
        .pair_cnt (pair_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_rdy(input logic a);
        return (pend.size() < 2) || a;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_out1 = '0;
        m_out2 = '0;
        m_ovr  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input logic e, input logic [7:0] d, input logic a);
        if (e && !model_rdy(a)) begin
            m_ovr = 1'b1;
        end else begin
            if (pend.size() == 2 && a) begin
                pend.delete();
                m_cnt = (m_cnt + 1) % 16;
            end
            if (e) begin
                pend.push_back(d);
                if (pend.size() == 1) m_out1 = d;
                else m_out2 = d;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".out1"}, 32'(out1), 32'(m_out1));
        check_val({tag, ".out2"}, 32'(out2), 32'(m_out2));
        check_val({tag, ".valid"}, 32'(valid), 32'(pend.size() == 2));
        check_val({tag, ".ovr"}, 32'(ovr), 32'(m_ovr));
        check_val({tag, ".cnt"}, 32'(pair_cnt), 32'(m_cnt));
    endtask

    task automatic step(input logic e, input logic [7:0] d, input logic a, input string tag);
        @(negedge clk);
        en  = e;
        in  = d;
        ack = a;
        #1;
        check_val({tag, ".rdy"}, 32'(rdy), 32'(model_rdy(a)));
        @(posedge clk);
        model_step(e, d, a);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        ack = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        check_val("rst_rdy", 32'(rdy), 32'd1);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        in  = 8'h00;
        ack = 1'b0;
        model_reset();
        #3;
        check_outputs("por");
        check_val("por_rdy", 32'(rdy), 32'd1);
        // Hold reset across an edge with activity on the inputs.
        en  = 1'b1;
        in  = 8'h5A;
        ack = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        ack = 1'b0;
        #1;
        check_val("post_rst_rdy", 32'(rdy), 32'd1);

        // Basic pair and back-to-back replace.
        step(1'b1, 8'h9D, 1'b0, "pair_a");
        step(1'b1, 8'hBC, 1'b0, "pair_b");
        check_val("basic_out1", 32'(out1), 32'h9D);
        check_val("basic_out2", 32'(out2), 32'hBC);
        check_val("basic_valid", 32'(valid), 32'd1);
        check_val("basic_rdy", 32'(rdy), 32'd0);
        step(1'b1, 8'h9F, 1'b1, "b2b");
        check_val("b2b_out1", 32'(out1), 32'h9F);
        check_val("b2b_out2", 32'(out2), 32'hBC);
        check_val("b2b_valid", 32'(valid), 32'd0);
        check_val("b2b_cnt", 32'(pair_cnt), 32'd1);
        check_val("b2b_ovr", 32'(ovr), 32'd0);

        // Overrun while full; flag must survive the ack.
        step(1'b1, 8'h11, 1'b0, "ov_fill");
        step(1'b1, 8'h81, 1'b0, "ov_drop");
        check_val("ov_out1", 32'(out1), 32'h9F);
        check_val("ov_out2", 32'(out2), 32'h11);
        check_val("ov_flag", 32'(ovr), 32'd1);
        step(1'b0, 8'h00, 1'b1, "ov_ack");
        check_val("ov_sticky", 32'(ovr), 32'd1);
        check_val("ov_stale1", 32'(out1), 32'h9F);

        // Idle gaps with stray acks in EMPTY and HALF.
        step(1'b0, 8'hEE, 1'b1, "idle_e");
        step(1'b1, 8'h33, 1'b0, "gap_a");
        step(1'b0, 8'hEE, 1'b1, "idle_h");
        step(1'b0, 8'hEE, 1'b0, "idle_h2");
        step(1'b1, 8'h44, 1'b0, "gap_b");
        check_val("gap_valid", 32'(valid), 32'd1);
        check_val("gap_out1", 32'(out1), 32'h33);

        // Wrap of the pair counter.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'($urandom), 1'b0, "wrap_a");
            step(1'b1, 8'($urandom), 1'b0, "wrap_b");
            step(1'b0, 8'h00, 1'b1, "wrap_ack");
            if (i == 14) check_val("wrap_15", 32'(pair_cnt), 32'd15);
        end
        check_val("wrap_0", 32'(pair_cnt), 32'd0);

        // Asynchronous reset between edges while half full.
        step(1'b1, 8'hAD, 1'b0, "ar_half");
        check_val("ar_pre", 32'(out1), 32'hAD);
        do_reset();
        step(1'b1, 8'h21, 1'b0, "ar_next");
        check_val("ar_out1", 32'(out1), 32'h21);
        check_val("ar_valid", 32'(valid), 32'd0);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0), "rnd");
            if (i == 200) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
